// File: rtl/vga_rx_monitor.sv
// rtl/vga_rx_monitor.sv - VGA receive-side timing checker with pixel coordinate recovery
module vga_rx_monitor #(
    parameter int   H_DISPLAY   = 640,
    parameter int   H_TOTAL     = 800,
    parameter int   H_OFFSET    = 144,
    parameter int   V_DISPLAY   = 480,
    parameter int   V_TOTAL     = 525,
    parameter int   V_OFFSET    = 34,
    parameter logic SYNC_POL    = 1'b1,
    parameter int   LOCK_FRAMES = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       pix_tick_i,
    input  logic       h_sync_i,
    input  logic       v_sync_i,
    input  logic [2:0] rgb_i,
    output logic [9:0] pixel_x_o,
    output logic [9:0] pixel_y_o,
    output logic [2:0] pix_rgb_o,
    output logic       pix_valid_o,
    output logic       line_start_o,
    output logic       frame_start_o,
    output logic       locked_o,
    output logic       err_h_o,
    output logic       err_v_o
);

    localparam logic [10:0] H_TOTAL_W   = 11'(H_TOTAL);
    localparam logic [10:0] V_TOTAL_W   = 11'(V_TOTAL);
    localparam logic [9:0]  H_START     = 10'(H_OFFSET);
    localparam logic [9:0]  H_STOP      = 10'(H_OFFSET + H_DISPLAY);
    localparam logic [9:0]  V_START     = 10'(V_OFFSET);
    localparam logic [9:0]  V_STOP      = 10'(V_OFFSET + V_DISPLAY);
    localparam logic [9:0]  CNT_MAX     = 10'h3FF;
    localparam int          CW          = $clog2(LOCK_FRAMES + 1);
    localparam logic [CW-1:0] LOCK_TARGET = CW'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        LK_WAIT_REF,
        LK_COUNT,
        LK_LOCKED
    } lock_state_e;

    logic          s_h_q, s_v_q;
    logic [2:0]    s_rgb_q;
    logic [9:0]    hc_q, hc_d, vc_q, vc_d;
    logic          v_pend_q, v_pend_d;
    logic          h_seen_q, h_seen_d, v_seen_q, v_seen_d;
    logic          h_edge, v_edge, frame_ref;
    logic          bad_h, bad_v, err_any;
    lock_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dirty_q, dirty_d;
    logic          in_window;
    logic [9:0]    pix_x_d, pix_y_d;
    logic [9:0]    pixel_x_q, pixel_y_q;
    logic [2:0]    pix_rgb_q;
    logic          pix_valid_q, line_start_q, frame_start_q, err_h_q, err_v_q;

    // Edges compare the incoming sample with the previous registered one, so the
    // counters describe the same sample that s_rgb_q holds after the tick.
    assign h_edge    = (h_sync_i == SYNC_POL) && (s_h_q != SYNC_POL);
    assign v_edge    = (v_sync_i == SYNC_POL) && (s_v_q != SYNC_POL);
    assign frame_ref = h_edge && (v_pend_q || v_edge);
    assign err_any   = bad_h || bad_v;

    // Sample the raw sync and color inputs once per pixel tick
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s_h_q   <= ~SYNC_POL;
            s_v_q   <= ~SYNC_POL;
            s_rgb_q <= '0;
        end else if (pix_tick_i) begin
            s_h_q   <= h_sync_i;
            s_v_q   <= v_sync_i;
            s_rgb_q <= rgb_i;
        end
    end

    // Line/frame counters with length checks; first line and first frame are unchecked
    always_comb begin
        hc_d     = hc_q;
        vc_d     = vc_q;
        v_pend_d = v_pend_q;
        h_seen_d = h_seen_q;
        v_seen_d = v_seen_q;
        bad_h    = 1'b0;
        bad_v    = 1'b0;
        if (h_edge) begin
            hc_d     = '0;
            h_seen_d = 1'b1;
            if (h_seen_q && (({1'b0, hc_q} + 11'd1) != H_TOTAL_W)) begin
                bad_h = 1'b1;
            end
            if (frame_ref) begin
                vc_d     = '0;
                v_pend_d = 1'b0;
                v_seen_d = 1'b1;
                if (v_seen_q && (({1'b0, vc_q} + 11'd1) != V_TOTAL_W)) begin
                    bad_v = 1'b1;
                end
            end else if (vc_q != CNT_MAX) begin
                vc_d = vc_q + 10'd1;
            end
        end else begin
            if (v_edge) begin
                v_pend_d = 1'b1;
            end
            if (hc_q != CNT_MAX) begin
                hc_d = hc_q + 10'd1;
                if (hc_q == CNT_MAX - 10'd1) begin
                    bad_h = 1'b1;
                end
            end
        end
    end

    // Counter state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hc_q     <= '0;
            vc_q     <= '0;
            v_pend_q <= 1'b0;
            h_seen_q <= 1'b0;
            v_seen_q <= 1'b0;
        end else if (pix_tick_i) begin
            hc_q     <= hc_d;
            vc_q     <= vc_d;
            v_pend_q <= v_pend_d;
            h_seen_q <= h_seen_d;
            v_seen_q <= v_seen_d;
        end
    end

    // Lock tracking: a frame counts only if no error hit it since the previous reference edge
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dirty_d = dirty_q;
        unique case (state_q)
            LK_WAIT_REF: begin
                if (frame_ref) begin
                    state_d = LK_COUNT;
                    cnt_d   = '0;
                    dirty_d = 1'b0;
                end
            end
            LK_COUNT, LK_LOCKED: begin
                if (frame_ref) begin
                    dirty_d = 1'b0;
                    if (!dirty_q && !err_any && (cnt_q != LOCK_TARGET)) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (err_any) begin
                    dirty_d = 1'b1;
                end
                if (err_any) begin
                    cnt_d = '0;
                end
                state_d = (cnt_d == LOCK_TARGET) ? LK_LOCKED : LK_COUNT;
            end
            default: state_d = LK_WAIT_REF;
        endcase
    end

    // Lock state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= LK_WAIT_REF;
            cnt_q   <= '0;
            dirty_q <= 1'b0;
        end else if (pix_tick_i) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dirty_q <= dirty_d;
        end
    end

    assign in_window = (hc_q >= H_START) && (hc_q < H_STOP) &&
                       (vc_q >= V_START) && (vc_q < V_STOP);
    assign pix_x_d   = hc_q - H_START;
    assign pix_y_d   = vc_q - V_START;

    // Output stage: pulses last one clk, coordinates and color hold outside the window
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
            pix_rgb_q     <= '0;
            pix_valid_q   <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            err_h_q       <= 1'b0;
            err_v_q       <= 1'b0;
        end else begin
            pix_valid_q   <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            err_h_q       <= 1'b0;
            err_v_q       <= 1'b0;
            if (pix_tick_i) begin
                err_h_q <= bad_h;
                err_v_q <= bad_v;
                if ((state_q == LK_LOCKED) && in_window) begin
                    pixel_x_q     <= pix_x_d;
                    pixel_y_q     <= pix_y_d;
                    pix_rgb_q     <= s_rgb_q;
                    pix_valid_q   <= 1'b1;
                    line_start_q  <= (pix_x_d == 10'd0);
                    frame_start_q <= (pix_x_d == 10'd0) && (pix_y_d == 10'd0);
                end
            end
        end
    end

    assign pixel_x_o     = pixel_x_q;
    assign pixel_y_o     = pixel_y_q;
    assign pix_rgb_o     = pix_rgb_q;
    assign pix_valid_o   = pix_valid_q;
    assign line_start_o  = line_start_q;
    assign frame_start_o = frame_start_q;
    assign locked_o      = (state_q == LK_LOCKED);
    assign err_h_o       = err_h_q;
    assign err_v_o       = err_v_q;

endmodule

// File: tb/tb_vga_rx_monitor.sv
// tb/tb_vga_rx_monitor.sv - randomized self-checking bench for vga_rx_monitor
module tb_vga_rx_monitor;

    localparam int HD = 16, HT = 28, HO = 8, HSW = 4;
    localparam int VD = 8, VT = 14, VO = 4, VSW = 2;
    localparam int LF = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pix_tick = 1'b0;
    logic       h_sync = 1'b0;
    logic       v_sync = 1'b0;
    logic [2:0] rgb = 3'd0;
    logic [9:0] pixel_x, pixel_y;
    logic [2:0] pix_rgb;
    logic       pix_valid, line_start, frame_start, locked, err_h, err_v;

    vga_rx_monitor #(
        .H_DISPLAY(HD), .H_TOTAL(HT), .H_OFFSET(HO),
        .V_DISPLAY(VD), .V_TOTAL(VT), .V_OFFSET(VO),
        .SYNC_POL(1'b1), .LOCK_FRAMES(LF)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .pix_tick_i(pix_tick),
        .h_sync_i(h_sync), .v_sync_i(v_sync), .rgb_i(rgb),
        .pixel_x_o(pixel_x), .pixel_y_o(pixel_y), .pix_rgb_o(pix_rgb),
        .pix_valid_o(pix_valid), .line_start_o(line_start), .frame_start_o(frame_start),
        .locked_o(locked), .err_h_o(err_h), .err_v_o(err_v)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Reference model: sample counts since the last h-edge / frame reference, frame bookkeeping
    bit m_ph, m_pv, m_pend, m_hseen, m_vseen, m_fseen, m_dirty, m_locked;
    int m_hc, m_vc, m_clean, m_refs;
    bit e_pv;
    int e_x, e_y, e_rgb, h_x, h_y, h_rgb;

    // Observation tallies
    int n_valid, n_ls, n_fs, n_errh, n_errv, last_x, last_y, lock_on_err;
    int bad_out, bad_err, bad_pulse, bad_grad;
    int lock_ref_idx;
    bit prev_locked;
    bit grad_mode;

    task automatic model_reset();
        m_ph = 0; m_pv = 0; m_pend = 0; m_hseen = 0; m_vseen = 0;
        m_fseen = 0; m_dirty = 0; m_locked = 0;
        m_hc = 0; m_vc = 0; m_clean = 0; m_refs = 0;
        e_pv = 0; e_x = 0; e_y = 0; e_rgb = 0; h_x = 0; h_y = 0; h_rgb = 0;
        lock_ref_idx = 0; prev_locked = 0;
    endtask

    task automatic clear_counts();
        n_valid = 0; n_ls = 0; n_fs = 0; n_errh = 0; n_errv = 0;
        last_x = -1; last_y = -1; lock_on_err = -1;
    endtask

    task automatic check_model(input string tag);
        check_eq({tag, "_outputs"}, bad_out, 0);
        check_eq({tag, "_err_lock"}, bad_err, 0);
        check_eq({tag, "_idle_pulses"}, bad_pulse, 0);
        check_eq({tag, "_gradient"}, bad_grad, 0);
        bad_out = 0; bad_err = 0; bad_pulse = 0; bad_grad = 0;
    endtask

    task automatic check_full_frame(input string tag);
        check_eq({tag, "_valid_count"}, n_valid, HD * VD);
        check_eq({tag, "_line_starts"}, n_ls, VD);
        check_eq({tag, "_frame_starts"}, n_fs, 1);
        check_eq({tag, "_last_x"}, last_x, HD - 1);
        check_eq({tag, "_last_y"}, last_y, VD - 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_pixel_x"}, int'(pixel_x), 0);
        check_eq({tag, "_pixel_y"}, int'(pixel_y), 0);
        check_eq({tag, "_pix_rgb"}, int'(pix_rgb), 0);
        check_eq({tag, "_pix_valid"}, int'(pix_valid), 0);
        check_eq({tag, "_line_start"}, int'(line_start), 0);
        check_eq({tag, "_frame_start"}, int'(frame_start), 0);
        check_eq({tag, "_locked"}, int'(locked), 0);
        check_eq({tag, "_err_h"}, int'(err_h), 0);
        check_eq({tag, "_err_v"}, int'(err_v), 0);
    endtask

    // One pixel tick: drive a sample, observe the clk after the tick edge, then idle clocks
    task automatic tick(input bit h, input bit v, input logic [2:0] c);
        bit hedge, vedge, eh, ev, is_ref, exp_ls, exp_fs, inwin;
        int idle;
        h_sync = h; v_sync = v; rgb = c; pix_tick = 1'b1;
        @(negedge clk);
        pix_tick = 1'b0;
        // pixel outputs belong to the previous sample
        exp_ls = e_pv && (e_x == 0);
        exp_fs = exp_ls && (e_y == 0);
        if (e_pv) begin h_x = e_x; h_y = e_y; h_rgb = e_rgb; end
        if (pix_valid !== e_pv || line_start !== exp_ls || frame_start !== exp_fs ||
            int'(pixel_x) != h_x || int'(pixel_y) != h_y || int'(pix_rgb) != h_rgb) bad_out++;
        if (pix_valid) begin
            n_valid++; last_x = int'(pixel_x); last_y = int'(pixel_y);
            if (grad_mode && pix_rgb != pixel_x[2:0]) bad_grad++;
        end
        n_ls += int'(line_start);
        n_fs += int'(frame_start);
        // model consumes the current sample
        hedge = h && !m_ph; vedge = v && !m_pv; m_ph = h; m_pv = v;
        eh = 0; ev = 0; is_ref = 0;
        if (hedge) begin
            if (m_hseen && (m_hc + 1) != HT) eh = 1;
            m_hseen = 1; m_hc = 0;
            if (m_pend || vedge) begin
                is_ref = 1; m_refs++;
                if (m_vseen && (m_vc + 1) != VT) ev = 1;
                m_vseen = 1; m_vc = 0; m_pend = 0;
            end else if (m_vc < 1023) m_vc++;
        end else begin
            if (vedge) m_pend = 1;
            if (m_hc < 1023) begin
                m_hc++;
                if (m_hc == 1023) eh = 1;
            end
        end
        if (is_ref) begin
            if (m_fseen && !m_dirty && !(eh || ev) && m_clean < LF) m_clean++;
            m_fseen = 1; m_dirty = 0;
        end else if (eh || ev) m_dirty = 1;
        if (eh || ev) m_clean = 0;
        m_locked = (m_clean >= LF);
        if (err_h !== eh || err_v !== ev || locked !== m_locked) bad_err++;
        n_errh += int'(err_h);
        n_errv += int'(err_v);
        if (err_h || err_v) lock_on_err = int'(locked);
        if (locked && !prev_locked) lock_ref_idx = m_refs;
        prev_locked = locked;
        inwin = (m_hc >= HO) && (m_hc < HO + HD) && (m_vc >= VO) && (m_vc < VO + VD);
        e_pv = m_locked && inwin; e_x = m_hc - HO; e_y = m_vc - VO; e_rgb = int'(c);
        // mostly clk/2 pacing with occasional longer gaps or back-to-back ticks
        idle = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : 1;
        repeat (idle) begin
            @(negedge clk);
            if (pix_valid || line_start || frame_start || err_h || err_v) bad_pulse++;
        end
    endtask

    task automatic send_line(input int ln, input int h0, input int h1, input bit hs_on);
        logic [2:0] c;
        int x;
        for (int h = h0; h < h1; h++) begin
            x = h - HO;
            c = 3'($urandom_range(0, 7));
            if (grad_mode && x >= 0 && x < HD && ln >= VO && ln < VO + VD) c = 3'(x);
            tick(hs_on && (h < HSW), ln < VSW, c);
        end
    endtask

    task automatic send_frame(input int nlines, input int short_ln);
        for (int ln = 0; ln < nlines; ln++) begin
            send_line(ln, 0, (ln == short_ln) ? HT - 1 : HT, 1'b1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        model_reset();
        clear_counts();
        bad_out = 0; bad_err = 0; bad_pulse = 0; bad_grad = 0;
        grad_mode = 0;

        // Reset with random activity on every input
        rst_n = 1'b0;
        repeat (20) begin
            @(negedge clk);
            h_sync = 1'($urandom); v_sync = 1'($urandom);
            rgb = 3'($urandom); pix_tick = 1'($urandom);
        end
        check_reset_outputs("reset");
        @(negedge clk);
        pix_tick = 1'b0;
        rst_n = 1'b1;

        // Release mid-frame, then acquire lock
        for (int ln = 5; ln < VT; ln++) send_line(ln, (ln == 5) ? 10 : 0, HT, 1'b1);
        check_eq("lock_after_partial", int'(locked), 0);
        send_frame(VT, -1);
        send_frame(VT, -1);
        check_eq("lock_before_third_ref", int'(locked), 0);
        check_model("acquire");

        // Gradient frame once locked
        clear_counts();
        grad_mode = 1;
        send_frame(VT, -1);
        check_eq("lock_ref_index", lock_ref_idx, 3);
        check_full_frame("gradient");
        check_model("gradient");

        // Random color frame
        clear_counts();
        grad_mode = 0;
        send_frame(VT, -1);
        check_full_frame("random_rgb");
        check_eq("random_rgb_err_h", n_errh, 0);
        check_model("random_rgb");

        // One short line inside a locked frame
        clear_counts();
        send_frame(VT, 6);
        check_eq("short_line_err_h", n_errh, 1);
        check_eq("short_line_lock_on_err", lock_on_err, 0);
        check_eq("short_line_valid", n_valid, 3 * HD);
        clear_counts();
        send_frame(VT, -1);
        send_frame(VT, -1);
        check_eq("relock_gap_valid", n_valid, 0);
        check_eq("relock_gap_locked", int'(locked), 0);
        clear_counts();
        send_frame(VT, -1);
        check_full_frame("relocked");
        check_model("short_line");

        // h_sync stuck deasserted long enough for the line counter to saturate
        clear_counts();
        for (int ln = 0; ln < 3; ln++) send_line(ln, 0, HT, 1'b1);
        send_line(3, 0, 1100, 1'b0);
        check_eq("stuck_h_err_h", n_errh, 1);
        check_eq("stuck_h_locked", int'(locked), 0);
        for (int ln = 4; ln < VT; ln++) send_line(ln, 0, HT, 1'b1);
        send_frame(VT, -1);
        check_model("stuck_h");

        // Frame one line short
        clear_counts();
        send_frame(VT - 1, -1);
        send_frame(VT, -1);
        check_eq("short_frame_err_v", n_errv, 1);
        check_eq("short_frame_err_h", n_errh, 0);
        check_model("short_frame");

        // Relock, then reset in the middle of an active line
        send_frame(VT, -1);
        for (int ln = 0; ln < 7; ln++) send_line(ln, 0, HT, 1'b1);
        check_eq("pre_reset_locked", int'(locked), 1);
        send_line(7, 0, 15, 1'b1);
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("mid_line_reset");
        repeat (4) begin
            @(negedge clk);
            h_sync = 1'($urandom); v_sync = 1'($urandom); rgb = 3'($urandom);
        end
        model_reset();
        clear_counts();
        rst_n = 1'b1;
        send_line(7, 15, HT, 1'b1);
        for (int ln = 8; ln < VT; ln++) send_line(ln, 0, HT, 1'b1);
        send_frame(VT, -1);
        send_frame(VT, -1);
        check_eq("post_reset_valid_before_lock", n_valid, 0);
        clear_counts();
        send_frame(VT, -1);
        check_eq("post_reset_lock_ref_index", lock_ref_idx, 3);
        check_full_frame("post_reset");
        check_model("post_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
